// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers ALU results, performs CP (store) / GP (load) over req/ack,
// and emits one write-back record per instruction. Optional macro: STORE_FORWARD_EN.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [31:0]       rd_out,
    input  logic              wr_enable,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [31:0]       mem_out,
    input  logic [31:0]       rd_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              mem_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0] OP_CP = 5'd6;
    localparam logic [4:0] OP_GP = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memReq_q, memReq_d;
    logic              memWe_q, memWe_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [REG_W-1:0]  loadReg_q, loadReg_d;
    logic              wbValid_q, wbValid_d;
    logic              wbWe_q, wbWe_d;
    logic [REG_W-1:0]  wbReg_q, wbReg_d;
    logic [DATA_W-1:0] wbData_q, wbData_d;
    logic              memErr_q, memErr_d;

    logic accept;
    logic aluWrites;
    logic fwdHit;

`ifdef STORE_FORWARD_EN
    logic              fwdValid_q, fwdValid_d;
    logic [ADDR_W-1:0] fwdAddr_q, fwdAddr_d;
    logic [DATA_W-1:0] fwdData_q, fwdData_d;

    assign fwdHit = fwdValid_q && (fwdAddr_q == mem_out[ADDR_W-1:0]);
`else
    assign fwdHit = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign stall     = ~in_ready;
    assign accept    = in_valid & in_ready;
    // NOP, branches and undefined opcodes produce a record that never writes the register file
    assign aluWrites = !((opcode == 5'd0) || (opcode == 5'd7) || (opcode == 5'd8) || (opcode > 5'd10));

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign wb_valid  = wbValid_q;
    assign wb_we     = wbWe_q;
    assign wb_reg    = wbReg_q;
    assign wb_data   = wbData_q;
    assign mem_err   = memErr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            loadReg_q  <= '0;
            wbValid_q  <= 1'b0;
            wbWe_q     <= 1'b0;
            wbReg_q    <= '0;
            wbData_q   <= '0;
            memErr_q   <= 1'b0;
`ifdef STORE_FORWARD_EN
            fwdValid_q <= 1'b0;
            fwdAddr_q  <= '0;
            fwdData_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memReq_q   <= memReq_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            loadReg_q  <= loadReg_d;
            wbValid_q  <= wbValid_d;
            wbWe_q     <= wbWe_d;
            wbReg_q    <= wbReg_d;
            wbData_q   <= wbData_d;
            memErr_q   <= memErr_d;
`ifdef STORE_FORWARD_EN
            fwdValid_q <= fwdValid_d;
            fwdAddr_q  <= fwdAddr_d;
            fwdData_q  <= fwdData_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memReq_d   = memReq_q;
        memWe_d    = memWe_q;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        loadReg_d  = loadReg_q;
        wbValid_d  = 1'b0;
        wbWe_d     = 1'b0;
        wbReg_d    = wbReg_q;
        wbData_d   = wbData_q;
        memErr_d   = memErr_q;
`ifdef STORE_FORWARD_EN
        fwdValid_d = fwdValid_q;
        fwdAddr_d  = fwdAddr_q;
        fwdData_d  = fwdData_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_CP) begin
                        state_d    = ACCESS;
                        cnt_d      = '0;
                        memReq_d   = 1'b1;
                        memWe_d    = 1'b1;
                        memAddr_d  = rd_mem[ADDR_W-1:0];
                        memWdata_d = mem_result;
                        loadReg_d  = rd_mem[REG_W-1:0];
                    end else if (opcode == OP_GP && fwdHit) begin
                        wbValid_d = 1'b1;
                        wbWe_d    = 1'b1;
                        wbReg_d   = rd_mem[REG_W-1:0];
`ifdef STORE_FORWARD_EN
                        wbData_d  = fwdData_q;
`endif
                    end else if (opcode == OP_GP) begin
                        state_d   = ACCESS;
                        cnt_d     = '0;
                        memReq_d  = 1'b1;
                        memWe_d   = 1'b0;
                        memAddr_d = mem_out[ADDR_W-1:0];
                        loadReg_d = rd_mem[REG_W-1:0];
                    end else begin
                        wbValid_d = 1'b1;
                        wbWe_d    = aluWrites & wr_enable;
                        wbReg_d   = rd_out[REG_W-1:0];
                        wbData_d  = alu_result;
                    end
                end
            end

            ACCESS: begin
                // an ack in the final counted cycle still completes normally
                if (mem_ack) begin
                    state_d   = RESP;
                    memReq_d  = 1'b0;
                    wbValid_d = 1'b1;
                    if (!memWe_q) begin
                        wbWe_d   = 1'b1;
                        wbReg_d  = loadReg_q;
                        wbData_d = mem_rdata;
                    end
`ifdef STORE_FORWARD_EN
                    if (memWe_q) begin
                        fwdValid_d = 1'b1;
                        fwdAddr_d  = memAddr_q;
                        fwdData_d  = memWdata_q;
                    end
`endif
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = RESP;
                    memReq_d  = 1'b0;
                    memErr_d  = 1'b1;
                    wbValid_d = 1'b1;
`ifdef STORE_FORWARD_EN
                    fwdValid_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized traffic against
// a behavioural memory/forwarding model. Build with +define+STORE_FORWARD_EN to cover forwarding.
module tb_mem_access_stage;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 16;
    localparam int REG_W   = 4;
    localparam int TIMEOUT = 255;
`ifdef STORE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        opcode = '0;
    logic [DATA_W-1:0] alu_result = '0;
    logic [31:0]       rd_out = '0;
    logic              wr_enable = 1'b0;
    logic [DATA_W-1:0] mem_result = '0;
    logic [31:0]       mem_out = '0;
    logic [31:0]       rd_mem = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              wb_valid;
    logic              wb_we;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              mem_err;

    int nAsserts = 0;
    int nFail    = 0;
    int wbCount  = 0;

    // reference state: architectural memory contents, forwarding entry, sticky error
    logic [31:0] refMem [logic [15:0]];
    logic [31:0] tbMem  [logic [15:0]];
    bit          fwdValid = 1'b0;
    logic [15:0] fwdAddr  = '0;
    bit          errModel = 1'b0;

    mem_access_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .alu_result(alu_result),
        .rd_out    (rd_out),
        .wr_enable (wr_enable),
        .mem_result(mem_result),
        .mem_out   (mem_out),
        .rd_mem    (rd_mem),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_we     (wb_we),
        .wb_reg    (wb_reg),
        .wb_data   (wb_data),
        .stall     (stall),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wb_valid === 1'b1) wbCount <= wbCount + 1;
    end

    function automatic logic [31:0] readRef(input logic [15:0] a);
        return refMem.exists(a) ? refMem[a] : {a, ~a};
    endfunction

    function automatic logic [31:0] readTb(input logic [15:0] a);
        return tbMem.exists(a) ? tbMem[a] : {a, ~a};
    endfunction

    function automatic bit writesReg(input logic [4:0] op);
        return !(op == 5'd0 || op == 5'd7 || op == 5'd8 || op > 5'd10);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstInReady", in_ready, 1);
        checkOutput("rstStall", stall, 0);
        checkOutput("rstMemReq", mem_req, 0);
        checkOutput("rstWbValid", wb_valid, 0);
        checkOutput("rstMemErr", mem_err, 0);
        rst      = 1'b0;
        errModel = 1'b0;
        fwdValid = 1'b0;
    endtask

    // waits < 0 means never acknowledge; hold keeps in_valid asserted after acceptance
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] alu, input logic [31:0] rdOut,
                                 input logic wr, input logic [31:0] memRes, input logic [31:0] memOut,
                                 input logic [31:0] rdMem, input int waits, input bit hold);
        bit          isStore, isLoad, viaMem, expWe, timedOut;
        logic [15:0] addr;
        logic [31:0] expData;
        logic [3:0]  expReg;
        int          cycles, guard;

        isStore = (op == 5'd6);
        isLoad  = (op == 5'd10);
        addr    = isStore ? rdMem[15:0] : memOut[15:0];
        viaMem  = isStore || (isLoad && !(fwdValid && fwdAddr == addr));
        expReg  = rdOut[3:0];
        expData = alu;
        expWe   = 1'b0;
        if (isLoad) begin
            expWe   = !(viaMem && waits < 0);
            expReg  = rdMem[3:0];
            expData = readRef(addr);
        end else if (!isStore) begin
            expWe = writesReg(op) && wr;
        end

        guard = 0;
        while (in_ready !== 1'b1 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("readyBeforeIssue", in_ready, 1);

        opcode     = op;
        alu_result = alu;
        rd_out     = rdOut;
        wr_enable  = wr;
        mem_result = memRes;
        mem_out    = memOut;
        rd_mem     = rdMem;
        in_valid   = 1'b1;
        mem_ack    = 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        if (!hold) in_valid = 1'b0;

        if (viaMem) begin
            cycles = 0;
            while (mem_req === 1'b1 && cycles < TIMEOUT + 4) begin
                checkOutput("memWe", mem_we, isStore);
                checkOutput("memAddr", mem_addr, addr);
                if (isStore) checkOutput("memWdata", mem_wdata, memRes);
                checkOutput("stallDuringAccess", stall, 1);
                checkOutput("noWbDuringAccess", wb_valid, 0);
                if (cycles == waits) begin
                    if (mem_we === 1'b1) tbMem[mem_addr] = mem_wdata;
                    mem_rdata = readTb(mem_addr);
                    mem_ack   = 1'b1;
                end
                cycles++;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom();
            end
            checkOutput("memReqCycles", cycles, (waits < 0) ? TIMEOUT : waits + 1);
        end else begin
            checkOutput("noMemReq", mem_req, 0);
        end

        checkOutput("wbValid", wb_valid, 1);
        checkOutput("wbWe", wb_we, expWe);
        if (expWe) begin
            checkOutput("wbReg", wb_reg, expReg);
            checkOutput("wbData", wb_data, expData);
        end

        timedOut = viaMem && (waits < 0);
        if (timedOut) begin
            errModel = 1'b1;
            fwdValid = 1'b0;
        end else if (isStore) begin
            refMem[addr] = memRes;
            fwdValid     = FWD;
            fwdAddr      = addr;
        end
        checkOutput("memErr", mem_err, errModel);
        checkOutput("readyAfterRecord", in_ready, viaMem ? 0 : 1);
    endtask

    initial begin
        int          base;
        logic [4:0]  op;
        logic [31:0] r32;
        logic [15:0] a;
        int          waits;

        refMem[16'h0011] = 32'h12345678;
        tbMem[16'h0011]  = 32'h12345678;

        doReset();

        // basic ALU op, CP with two wait states, zero-wait GP
        applyStimulus(5'd5, 32'h2A, 32'd3, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(5'd6, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h10, 2, 1'b0);
        applyStimulus(5'd10, 32'h0, 32'h0, 1'b0, 32'h0, 32'h11, 32'd7, 0, 1'b0);

        // non-writing opcodes still produce records
        applyStimulus(5'd0, 32'h11, 32'd2, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(5'd8, 32'h22, 32'd4, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        applyStimulus(5'd17, 32'h33, 32'd5, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);

        // ack in the timeout cycle wins, then a real timeout, then normal ALU op
        applyStimulus(5'd10, 32'h0, 32'h0, 1'b0, 32'h0, 32'h30, 32'd9, TIMEOUT - 1, 1'b0);
        applyStimulus(5'd10, 32'h0, 32'h0, 1'b0, 32'h0, 32'h31, 32'd9, -1, 1'b0);
        applyStimulus(5'd3, 32'hCAFE, 32'd12, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);

        // reset in the middle of an access
        @(negedge clk);
        opcode   = 5'd10;
        mem_out  = 32'h40;
        rd_mem   = 32'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("midRstReqBefore", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstReq", mem_req, 0);
        checkOutput("midRstWb", wb_valid, 0);
        checkOutput("midRstReady", in_ready, 1);
        checkOutput("midRstErr", mem_err, 0);
        rst      = 1'b0;
        errModel = 1'b0;
        fwdValid = 1'b0;
        @(negedge clk);
        checkOutput("midRstNoWb", wb_valid, 0);

        // back-to-back 5, 6, 5 with in_valid held high
        base = wbCount;
        applyStimulus(5'd5, 32'hA1, 32'd1, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b1);
        applyStimulus(5'd6, 32'h0, 32'h0, 1'b0, 32'hB2, 32'h0, 32'h50, 1, 1'b1);
        applyStimulus(5'd5, 32'hC3, 32'd2, 1'b1, 32'h0, 32'h0, 32'h0, 0, 1'b0);
        @(negedge clk);
        checkOutput("b2bPulseCount", wbCount - base, 3);
        checkOutput("wbPulseEnds", wb_valid, 0);

        // store then load to the same address (forwarded when enabled)
        applyStimulus(5'd6, 32'h0, 32'h0, 1'b0, 32'h55, 32'h0, 32'h20, 0, 1'b0);
        applyStimulus(5'd10, 32'h0, 32'h0, 1'b0, 32'h0, 32'h20, 32'd6, 1, 1'b0);

        // randomized traffic over a small address window so loads hit recent stores
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1:    op = 5'd6;
                2, 3:    op = 5'd10;
                default: op = 5'($urandom_range(0, 31));
            endcase
            r32   = $urandom();
            a     = 16'h0100 + 16'($urandom_range(0, 7));
            waits = $urandom_range(0, 3);
            applyStimulus(op, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                          {r32[31:16], a}, {r32[15:0], a}, waits, 1'b0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
